// File: rtl/imm_pkg.sv
// Shared constants, FSM state type and the power-on immediate table for the
// immediate value encoder.
package imm_pkg;

  localparam int VAL_W_DEF   = 8;
  localparam int DEPTH_DEF   = 32;
  localparam int INDEX_W_DEF = $clog2(DEPTH_DEF);
  localparam int IMM_N       = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  // Power-on contents of the immediate table; entries at or beyond IMM_N are never loaded.
  function automatic logic [7:0] imm_entry(input int idx);
    logic [7:0] v;
    case (idx)
      0:       v = 8'd0;
      1:       v = 8'd1;
      2:       v = 8'd2;
      3:       v = 8'd3;
      4:       v = 8'd4;
      5:       v = 8'd5;
      6:       v = 8'd6;
      7:       v = 8'd14;
      8:       v = 8'd16;
      9:       v = 8'd30;
      10:      v = 8'd31;
      11:      v = 8'd32;
      12:      v = 8'd33;
      13:      v = 8'd60;
      14:      v = 8'd91;
      15:      v = 8'd109;
      16:      v = 8'd142;
      17:      v = 8'd170;
      18:      v = 8'd204;
      19:      v = 8'd224;
      20:      v = 8'd225;
      21:      v = 8'd240;
      22:      v = 8'd247;
      23:      v = 8'd254;
      24:      v = 8'd85;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/imm_value_encoder.sv
// Reverse immediate lookup: sequentially scans a writable table, one entry per
// cycle and lowest index first, for the requested value.
module imm_value_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int INDEX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [VAL_W-1:0]   req_value,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [INDEX_W-1:0] resp_index,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [VAL_W-1:0]   wr_value,
  input  logic               clear,
  output logic               busy,
  output logic               wr_drop
);

  enc_state_t         state_q;
  logic [INDEX_W-1:0] ptr_q;
  logic [VAL_W-1:0]   key_q;
  logic [VAL_W-1:0]   tbl_val_q [DEPTH];
  logic               tbl_vld_q [DEPTH];
  logic               resp_valid_q;
  logic               resp_hit_q;
  logic [INDEX_W-1:0] resp_index_q;
  logic               wr_drop_q;

  logic match_d;
  logic last_d;

  // Compare the entry under the scan pointer and flag the final entry.
  always_comb begin
    match_d = 1'b0;
    last_d  = 1'b0;
    if (tbl_vld_q[ptr_q] && (tbl_val_q[ptr_q] == key_q)) begin
      match_d = 1'b1;
    end else begin
      match_d = 1'b0;
    end
    if (ptr_q == INDEX_W'(DEPTH - 1)) begin
      last_d = 1'b1;
    end else begin
      last_d = 1'b0;
    end
  end

  // Search FSM, table storage and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      key_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      wr_drop_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_val_q[i] <= (i < IMM_N) ? VAL_W'(imm_entry(i)) : '0;
        tbl_vld_q[i] <= (i < IMM_N) ? 1'b1 : 1'b0;
      end
    end else begin
      wr_drop_q <= (wr_en || clear) && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
              tbl_vld_q[i] <= 1'b0;
            end
          end
          // Issued after the clear so a same-cycle write leaves its entry valid.
          if (wr_en) begin
            tbl_val_q[wr_index] <= wr_value;
            tbl_vld_q[wr_index] <= 1'b1;
          end
          if (req_valid) begin
            key_q   <= req_value;
            ptr_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (match_d) begin
            resp_hit_q   <= 1'b1;
            resp_index_q <= ptr_q;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (last_d) begin
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            ptr_q <= ptr_q + INDEX_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_index = resp_index_q;
  assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_imm_value_encoder.sv
// Directed bench for imm_value_encoder: a reference table model predicts each
// response, which is queued at request time and checked when the DUT answers.
module tb_imm_value_encoder;

  localparam int DEPTH = 32;
  localparam int VAL_W = 8;
  localparam int IW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [VAL_W-1:0] req_value;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic [IW-1:0] resp_index;
  logic          wr_en;
  logic [IW-1:0] wr_index;
  logic [VAL_W-1:0] wr_value;
  logic          clear;
  logic          busy;
  logic          wr_drop;

  always #5 clk = ~clk;

  imm_value_encoder #(.DEPTH(DEPTH), .VAL_W(VAL_W), .INDEX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_index(resp_index),
    .wr_en(wr_en), .wr_index(wr_index), .wr_value(wr_value),
    .clear(clear), .busy(busy), .wr_drop(wr_drop)
  );

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  logic [7:0] spec_tbl [25] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd14, 8'd16,
                                8'd30, 8'd31, 8'd32, 8'd33, 8'd60, 8'd91, 8'd109, 8'd142,
                                8'd170, 8'd204, 8'd224, 8'd225, 8'd240, 8'd247, 8'd254, 8'd85};
  logic [7:0] m_val [DEPTH];
  logic       m_vld [DEPTH];

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = (i < 25) ? spec_tbl[i] : 8'd0;
      m_vld[i] = (i < 25);
    end
  endtask

  function automatic exp_t m_lookup(logic [7:0] v);
    exp_t e;
    e.hit = 1'b0;
    e.idx = '0;
    e.lat = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && m_val[i] == v) begin
        e.hit = 1'b1;
        e.idx = IW'(i);
        e.lat = i + 1;
        return e;
      end
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a request (optionally with a same-cycle write/clear) and queue the model's answer.
  task automatic start(logic [7:0] v, logic we, logic [IW-1:0] wi, logic [7:0] wv, logic clr);
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1; req_value = v;
    wr_en = we; wr_index = wi; wr_value = wv; clear = clr;
    if (clr) for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    if (we) begin m_val[wi] = wv; m_vld[wi] = 1'b1; end
    sb.push_back(m_lookup(v));
    @(posedge clk);
    #1;
    req_valid = 1'b0; wr_en = 1'b0; clear = 1'b0;
    req_value = ~v;
    cyc = 0;
  endtask

  // Wait for the response, compare it to the queued expectation, optionally stall, then accept.
  task automatic finish_req(int hold);
    exp_t e;
    logic got;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("resp_arrived", got, 1);
    e = sb.pop_front();
    if (got) begin
      chk("latency", cyc, e.lat);
      chk("resp_hit", resp_hit, e.hit);
      chk("resp_index", resp_index, e.idx);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", resp_valid, 1);
        chk("hold_hit", resp_hit, e.hit);
        chk("hold_index", resp_index, e.idx);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("resp_cleared", resp_valid, 0);
      chk("idle_after", busy, 0);
    end
  endtask

  task automatic wr(logic we, logic [IW-1:0] wi, logic [7:0] wv, logic clr);
    @(negedge clk);
    wr_en = we; wr_index = wi; wr_value = wv; clear = clr;
    if (clr) for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    if (we) begin m_val[wi] = wv; m_vld[wi] = 1'b1; end
    @(posedge clk);
    #1;
    wr_en = 1'b0; clear = 1'b0;
    chk("idle_wr_no_drop", wr_drop, 0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; req_valid = 1'b0; req_value = '0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_index = '0; wr_value = '0; clear = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_index", resp_index, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    start(8'd33, 1'b0, '0, '0, 1'b0);  finish_req(0);
    start(8'd0,  1'b0, '0, '0, 1'b0);  finish_req(0);
    start(8'd85, 1'b0, '0, '0, 1'b0);  finish_req(0);
    start(8'd7,  1'b0, '0, '0, 1'b0);  finish_req(0);
    start(8'd254, 1'b0, '0, '0, 1'b0); finish_req(0);

    // Duplicate value at a lower index wins; clear leaves nothing matchable, not even 0.
    wr(1'b1, 5'd3, 8'd33, 1'b0);
    start(8'd33, 1'b0, '0, '0, 1'b0);  finish_req(0);
    wr(1'b0, 5'd0, 8'd0, 1'b1);
    start(8'd0,  1'b0, '0, '0, 1'b0);  finish_req(0);

    // Reset mid-scan abandons the search and restores the power-on table.
    start(8'd7, 1'b0, '0, '0, 1'b0);
    void'(sb.pop_back());
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_resp", seen, 0);
    start(8'd0,  1'b0, '0, '0, 1'b0);  finish_req(0);
    start(8'd33, 1'b0, '0, '0, 1'b0);  finish_req(0);

    // Write during SCAN is dropped with a pulse; response held stable while stalled.
    start(8'd85, 1'b0, '0, '0, 1'b0);
    tick();
    @(negedge clk);
    wr_en = 1'b1; wr_index = 5'd2; wr_value = 8'd85;
    @(posedge clk);
    #1;
    cyc++;
    wr_en = 1'b0;
    chk("scan_wr_drop", wr_drop, 1);
    tick();
    chk("scan_wr_drop_end", wr_drop, 0);
    finish_req(5);
    start(8'd85, 1'b0, '0, '0, 1'b0);  finish_req(0);

    // Same-cycle write and request: the search sees the new entry.
    start(8'd200, 1'b1, 5'd30, 8'd200, 1'b0); finish_req(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
